// File: rtl/rc_sched.sv
// Rational-resampler (R_UP/R_DOWN) sequencer: paces input slots, frame-start and output strobes.
// Optional RC_SCHED_STATS_EN adds a saturating underrun counter output.
module rc_sched #(
    parameter int R_UP   = 3,
    parameter int R_DOWN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ena_in,
    output logic       ena_io,
    output logic       ena_out,
    output logic [2:0] phase,
    output logic [3:0] count,
    output logic       busy
`ifdef RC_SCHED_STATS_EN
    ,
    output logic [7:0] underruns
`endif
);

    localparam int LAST = R_UP * R_DOWN - 1;

    if (R_UP < 2 || R_UP > 8 || R_DOWN < 2 || R_DOWN > 8 || R_UP * R_DOWN > 16) begin : g_bad_cfg
        $error("rc_sched: illegal R_UP/R_DOWN combination");
    end

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    state_t     state_q;
    logic [3:0] count_q, count_d;
    logic [2:0] phase_q, phase_d;
    logic       ena_in_q, ena_io_q, ena_out_q, busy_q;
    logic       slot, adv, at_dn, stop;

    // Slots recur every R_UP cycles; the last count of a frame is always a slot.
    assign slot     = ((int'(count_q) % R_UP) == (R_UP - 1));
    assign in_ready = (state_q == RUN && slot) || (state_q == STALL);
    assign adv      = (state_q == RUN && !slot) || (in_ready && in_valid);
    assign at_dn    = ((int'(count_q) % R_DOWN) == 0);
    assign stop     = adv && (int'(count_q) == LAST) && !run;
    assign count_d  = (int'(count_q) == LAST) ? 4'd0 : count_q + 4'd1;
    assign phase_d  = 3'(int'(count_q) / R_DOWN);

`ifdef RC_SCHED_STATS_EN
    logic [7:0] underruns_q;
    assign underruns = underruns_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            phase_q     <= '0;
            ena_in_q    <= 1'b0;
            ena_io_q    <= 1'b0;
            ena_out_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef RC_SCHED_STATS_EN
            underruns_q <= '0;
`endif
        end else begin
            ena_in_q  <= in_ready && in_valid;
            ena_io_q  <= adv && (count_q == 4'd0);
            ena_out_q <= adv && at_dn && (count_q != 4'd0);
            // count 0 is a multiple of R_DOWN, so this covers the ena_io load too
            if (adv && at_dn)
                phase_q <= phase_d;
            if (adv)
                count_q <= count_d;
            case (state_q)
                IDLE: begin
                    if (run)
                        state_q <= RUN;
                    busy_q <= run;
                end
                RUN: begin
                    if (slot && !in_valid) begin
                        state_q <= STALL;
`ifdef RC_SCHED_STATS_EN
                        if (underruns_q != 8'hFF)
                            underruns_q <= underruns_q + 8'd1;
`endif
                    end else if (stop) begin
                        state_q <= IDLE;
                    end
                    busy_q <= !stop;
                end
                STALL: begin
                    if (stop)
                        state_q <= IDLE;
                    else if (in_valid)
                        state_q <= RUN;
                    busy_q <= !stop;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ena_in  = ena_in_q;
    assign ena_io  = ena_io_q;
    assign ena_out = ena_out_q;
    assign phase   = phase_q;
    assign count   = count_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_rc_sched.sv
// Bench for rc_sched: directed frame table, corner sequences, and random traffic
// checked against a frame-level reference model for two parameter sets.
module tb_rc_sched;

    logic clk = 1'b0;
    logic reset, run, in_valid;
    logic       ir_a, ein_a, eio_a, eout_a, busy_a;
    logic [2:0] ph_a;
    logic [3:0] cnt_a;
    logic       ir_b, ein_b, eio_b, eout_b, busy_b;
    logic [2:0] ph_b;
    logic [3:0] cnt_b;
`ifdef RC_SCHED_STATS_EN
    logic [7:0] und_a, und_b;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rc_sched #(.R_UP(3), .R_DOWN(4)) dut_a (
        .clk(clk), .reset(reset), .run(run), .in_valid(in_valid),
        .in_ready(ir_a), .ena_in(ein_a), .ena_io(eio_a), .ena_out(eout_a),
        .phase(ph_a), .count(cnt_a), .busy(busy_a)
`ifdef RC_SCHED_STATS_EN
        , .underruns(und_a)
`endif
    );

    rc_sched #(.R_UP(2), .R_DOWN(5)) dut_b (
        .clk(clk), .reset(reset), .run(run), .in_valid(in_valid),
        .in_ready(ir_b), .ena_in(ein_b), .ena_io(eio_b), .ena_out(eout_b),
        .phase(ph_b), .count(cnt_b), .busy(busy_b)
`ifdef RC_SCHED_STATS_EN
        , .underruns(und_b)
`endif
    );

    // Reference model: st 0=idle 1=running 2=waiting for input
    typedef struct {
        int st; int cnt; int ph; int und;
        bit ein; bit eio; bit eout; bit busy;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset();
        mdl_t n;
        n.st = 0; n.cnt = 0; n.ph = 0; n.und = 0;
        n.ein = 0; n.eio = 0; n.eout = 0; n.busy = 0;
        return n;
    endfunction

    function automatic bit mdl_ready(mdl_t m, int ru);
        return (m.st == 1 && (m.cnt % ru) == ru - 1) || m.st == 2;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit r, bit v, int ru, int rd);
        mdl_t n;
        bit rdy, take, starve;
        int frame;
        n      = m;
        frame  = ru * rd;
        rdy    = mdl_ready(m, ru);
        take   = rdy && v;
        starve = m.st == 1 && rdy && !v;
        n.ein  = take;
        n.eio  = 0;
        n.eout = 0;
        if ((m.st == 1 && !rdy) || take) begin
            n.eio  = (m.cnt == 0);
            n.eout = (m.cnt != 0) && (m.cnt % rd == 0);
            if (n.eio || n.eout) n.ph = m.cnt / rd;
            n.cnt = (m.cnt + 1) % frame;
            if (m.cnt == frame - 1 && !r) n.st = 0;
            else n.st = 1;
        end else if (starve) begin
            n.st = 2;
            if (m.und < 255) n.und = m.und + 1;
        end else if (m.st == 0 && r) begin
            n.st = 1;
        end
        n.busy = (n.st != 0);
        return n;
    endfunction

    function automatic logic [11:0] mdl_vec(mdl_t m, int ru);
        return {mdl_ready(m, ru), m.ein, m.eio, m.eout, 3'(m.ph), 4'(m.cnt), m.busy};
    endfunction

    logic [11:0] va, vb;
    assign va = {ir_a, ein_a, eio_a, eout_a, ph_a, cnt_a, busy_a};
    assign vb = {ir_b, ein_b, eio_b, eout_b, ph_b, cnt_b, busy_b};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: apply inputs, compare, step model across posedge.
    task automatic cyc(input bit r, input bit v);
        run = r;
        in_valid = v;
        #1;
        chk("model_a", 32'(va), 32'(mdl_vec(ma, 3)));
        chk("model_b", 32'(vb), 32'(mdl_vec(mb, 2)));
`ifdef RC_SCHED_STATS_EN
        chk("und_a", 32'(und_a), 32'(ma.und));
        chk("und_b", 32'(und_b), 32'(mb.und));
`endif
        @(posedge clk);
        ma = mdl_step(ma, r, v, 3, 4);
        mb = mdl_step(mb, r, v, 2, 5);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        chk("rst_a", 32'(va), 32'd0);
        chk("rst_b", 32'(vb), 32'd0);
`ifdef RC_SCHED_STATS_EN
        chk("rst_und", 32'(und_a), 32'd0);
`endif
        ma = mdl_reset();
        mb = mdl_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_until(input int target);
        int n;
        n = 0;
        while (!(ma.st == 1 && ma.cnt == target) && n < 40) begin
            cyc(1, 1);
            n++;
        end
        if (n >= 40) chk("bound_run_until", 32'(n), 32'd0);
    endtask

    typedef struct {
        bit r; bit v;
        logic [3:0] cnt; bit ir; bit ein; bit eio; bit eout; logic [2:0] ph; bit busy;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int ein_n, eio_n, eout_n, out_ph, n;

        //            r  v  cnt ir ein eio eout ph busy
        tbl[0]  = '{1, 1, 0,  0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0,  0, 0, 0, 0, 0, 1};
        tbl[2]  = '{1, 1, 1,  0, 0, 1, 0, 0, 1};
        tbl[3]  = '{1, 1, 2,  1, 0, 0, 0, 0, 1};
        tbl[4]  = '{1, 1, 3,  0, 1, 0, 0, 0, 1};
        tbl[5]  = '{1, 1, 4,  0, 0, 0, 0, 0, 1};
        tbl[6]  = '{1, 1, 5,  1, 0, 0, 1, 1, 1};
        tbl[7]  = '{1, 1, 6,  0, 1, 0, 0, 1, 1};
        tbl[8]  = '{1, 1, 7,  0, 0, 0, 0, 1, 1};
        tbl[9]  = '{1, 1, 8,  1, 0, 0, 0, 1, 1};
        tbl[10] = '{1, 1, 9,  0, 1, 0, 1, 2, 1};
        tbl[11] = '{1, 1, 10, 0, 0, 0, 0, 2, 1};
        tbl[12] = '{1, 1, 11, 1, 0, 0, 0, 2, 1};
        tbl[13] = '{1, 1, 0,  0, 1, 0, 0, 2, 1};
        tbl[14] = '{1, 1, 1,  0, 0, 1, 0, 0, 1};

        reset = 1'b1; run = 1'b0; in_valid = 1'b0;
        ma = mdl_reset(); mb = mdl_reset();
        @(negedge clk);
        pulse_reset();

        // Steady-state default frame
        foreach (tbl[i]) begin
            run = tbl[i].r; in_valid = tbl[i].v;
            #1;
            chk($sformatf("tbl_%0d", i), 32'(va),
                32'({tbl[i].ir, tbl[i].ein, tbl[i].eio, tbl[i].eout, tbl[i].ph, tbl[i].cnt, tbl[i].busy}));
            cyc(tbl[i].r, tbl[i].v);
        end

        // Starvation at the count-5 slot
        pulse_reset();
        run_until(5);
        cyc(1, 0);
        for (int k = 0; k < 4; k++) begin
            chk("stall_cnt", 32'(cnt_a), 32'd5);
            chk("stall_strobes", 32'({ein_a, eio_a, eout_a}), 32'd0);
            chk("stall_busy", 32'(busy_a), 32'd1);
            cyc(1, 0);
        end
        cyc(1, 1);
        chk("resume_cnt", 32'(cnt_a), 32'd6);
        chk("resume_ein", 32'(ein_a), 32'd1);
`ifdef RC_SCHED_STATS_EN
        chk("stall_und", 32'(und_a), 32'd1);
`endif

        // Run dropped mid-frame finishes the frame
        pulse_reset();
        run_until(3);
        n = 0;
        while (ma.cnt != 11 && n < 40) begin cyc(0, 1); n++; end
        if (n >= 40) chk("bound_drop", 32'(n), 32'd0);
        chk("drop_last_busy", 32'(busy_a), 32'd1);
        cyc(0, 1);
        chk("drop_busy", 32'(busy_a), 32'd0);
        chk("drop_cnt", 32'(cnt_a), 32'd0);
        cyc(0, 1);
        chk("idle_hold", 32'({busy_a, cnt_a, ir_a}), 32'd0);

        // Reset mid-frame, then a fresh frame
        pulse_reset();
        run_until(7);
        pulse_reset();
        cyc(1, 1);
        cyc(1, 1);
        chk("fresh_io", 32'({eio_a, cnt_a}), 32'h11);

        // R_UP=2, R_DOWN=5 frame strobe census
        pulse_reset();
        cyc(1, 1);
        cyc(1, 1);
        ein_n = 0; eio_n = 0; eout_n = 0; out_ph = -1;
        for (int k = 0; k < 10; k++) begin
            ein_n += int'(ein_b); eio_n += int'(eio_b); eout_n += int'(eout_b);
            if (eout_b) out_ph = int'(ph_b);
            cyc(1, 1);
        end
        chk("b_ein", 32'(ein_n), 32'd5);
        chk("b_eio", 32'(eio_n), 32'd1);
        chk("b_eout", 32'(eout_n), 32'd1);
        chk("b_out_phase", 32'(out_ph), 32'd1);

        // Random traffic against the model
        pulse_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else cyc($urandom_range(0, 99) < 90, $urandom_range(0, 99) < 75);
        end

`ifdef RC_SCHED_STATS_EN
        pulse_reset();
        for (int k = 0; k < 300; k++) begin
            n = 0;
            while (!(ma.st == 1 && ma.cnt % 3 == 2) && n < 10) begin cyc(1, 1); n++; end
            cyc(1, 0);
            cyc(1, 1);
        end
        chk("und_sat", 32'(und_a), 32'd255);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
